// File: rtl/mux_arb_pkg.sv
// Shared encodings for the mux select arbiter: FSM states and select values.
package mux_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux_select_arbiter_mux2to1_bus.sv
// W-bit 2:1 datapath mux built from per-bit 2:1 cells; sel=0 picks a, sel=1 picks b.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

module mux2to1_bus #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    mux2to1 u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .sel(sel),
      .y  (y[i])
    );
  end
endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin, burst-limited arbiter for two requesters feeding a registered valid/ready slot.
// Optional MUX_ARB_STATS_EN adds saturating accepted-beat counters cnt_a/cnt_b.
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_a,
  input  logic [W-1:0] in_a,
  output logic         gnt_a,
  input  logic         req_b,
  input  logic [W-1:0] in_b,
  output logic         gnt_b,
  output logic         sel,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]  cnt_a,
  output logic [15:0]  cnt_b
`endif
);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] burst_cnt, cnt_nxt;
  logic          last_sel;
  logic          sel_hold;
  logic          stall;
  logic [W-1:0]  mux_y;

  assign stall = out_valid & ~out_ready;

  always_comb begin
    sel = sel_hold;
    case (state)
      ST_OWN_A: sel = SEL_A;
      ST_OWN_B: sel = SEL_B;
      default:  sel = sel_hold;
    endcase
  end

  assign gnt_a = (state == ST_OWN_A) & req_a & ~stall;
  assign gnt_b = (state == ST_OWN_B) & req_b & ~stall;

  mux2to1_bus #(.W(W)) u_mux (
    .a  (in_a),
    .b  (in_b),
    .sel(sel),
    .y  (mux_y)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = burst_cnt;
    if (!stall) begin
      case (state)
        ST_IDLE: begin
          if (req_a && req_b) state_nxt = (last_sel == SEL_B) ? ST_OWN_A : ST_OWN_B;
          else if (req_a)     state_nxt = ST_OWN_A;
          else if (req_b)     state_nxt = ST_OWN_B;
        end
        ST_OWN_A: begin
          if (!req_a) begin
            state_nxt = req_b ? ST_OWN_B : ST_IDLE;
            cnt_nxt   = '0;
          end else if (burst_cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (req_b) state_nxt = ST_OWN_B;
          end else begin
            cnt_nxt = burst_cnt + CW'(1);
          end
        end
        ST_OWN_B: begin
          if (!req_b) begin
            state_nxt = req_a ? ST_OWN_A : ST_IDLE;
            cnt_nxt   = '0;
          end else if (burst_cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (req_a) state_nxt = ST_OWN_A;
          end else begin
            cnt_nxt = burst_cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // last_sel starts at B so that A wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      last_sel  <= SEL_B;
      sel_hold  <= SEL_A;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
      sel_hold  <= sel;
      if (state_nxt == ST_OWN_A && state != ST_OWN_A) last_sel <= SEL_A;
      if (state_nxt == ST_OWN_B && state != ST_OWN_B) last_sel <= SEL_B;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (gnt_a || gnt_b) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (gnt_a && cnt_a != 16'hFFFF) cnt_a <= cnt_a + 16'd1;
      if (gnt_b && cnt_b != 16'hFFFF) cnt_b <= cnt_b + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed-vector bench for mux_select_arbiter (W=8, MAX_BURST=4).
module tb_mux_select_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic       gnt_a, gnt_b, sel, out_valid;
  logic [7:0] out_data;
`ifdef MUX_ARB_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_select_arbiter #(.W(8), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .in_a     (in_a),
    .gnt_a    (gnt_a),
    .req_b    (req_b),
    .in_b     (in_b),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef MUX_ARB_STATS_EN
    ,
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_data;
    int         own;

    // reset state
    #1;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_sel", sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);

    // both requesting: A first, alternating 4-beat bursts, no gaps
    do_reset();
    req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
    #1;
    chk("rr_idle_gnt_a", gnt_a, 0);
    chk("rr_idle_gnt_b", gnt_b, 0);
    step();
    exp_data = '0;
    for (int i = 1; i <= 12; i++) begin
      in_a = 8'(i);
      in_b = 8'(8'h80 + i);
      #1;
      own = ((i - 1) / 4) % 2;
      chk("rr_gnt_a", gnt_a, (own == 0) ? 1 : 0);
      chk("rr_gnt_b", gnt_b, (own == 1) ? 1 : 0);
      chk("rr_sel", sel, own);
      if (i > 1) begin
        chk("rr_valid", out_valid, 1);
        chk("rr_data", out_data, exp_data);
      end
      exp_data = (own == 1) ? 8'(8'h80 + i) : 8'(i);
      step();
    end

    // B alone: IDLE -> OWN_B, data one cycle after grant
    do_reset();
    req_b = 1'b1; in_b = 8'h5A; out_ready = 1'b1;
    #1;
    chk("b_idle_gnt_b", gnt_b, 0);
    chk("b_idle_sel", sel, 0);
    step();
    chk("b_sel", sel, 1);
    chk("b_gnt_b", gnt_b, 1);
    chk("b_valid_pre", out_valid, 0);
    step();
    chk("b_valid", out_valid, 1);
    chk("b_data", out_data, 8'h5A);
    req_b = 1'b0;

    // backpressure freezes grants, data and burst count
    do_reset();
    req_a = 1'b1; in_a = 8'h21; out_ready = 1'b1;
    step();
    chk("bp_gnt_first", gnt_a, 1);
    step();
    in_a = 8'h22;
    step();
    out_ready = 1'b0; in_a = 8'h33;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall_gnt_a", gnt_a, 0);
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_data", out_data, 8'h22);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_gnt_a", gnt_a, 1);
    step();
    req_b = 1'b1; in_a = 8'h44;
    #1;
    chk("bp_data33", out_data, 8'h33);
    chk("bp_last_beat_a", gnt_a, 1);
    step();
    chk("bp_switch_gnt_b", gnt_b, 1);
    chk("bp_switch_gnt_a", gnt_a, 0);
    chk("bp_data44", out_data, 8'h44);

    // A drops mid-burst: B takes over, burst count restarts
    do_reset();
    req_a = 1'b1; req_b = 1'b0; out_ready = 1'b1;
    step();
    step();
    step();
    req_a = 1'b0; req_b = 1'b1;
    #1;
    chk("drop_gnt_a", gnt_a, 0);
    chk("drop_gnt_b", gnt_b, 0);
    chk("drop_sel_a", sel, 0);
    step();
    chk("drop_sel_b", sel, 1);
    req_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drop_b_burst", gnt_b, 1);
      step();
    end
    chk("drop_back_a", gnt_a, 1);
    chk("drop_back_sel", sel, 0);

    // async reset mid-burst clears outputs before the next edge
    do_reset();
    req_a = 1'b1; in_a = 8'h77; out_ready = 1'b1;
    step();
    step();
    chk("ar_valid_pre", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_sel", sel, 0);
    chk("ar_gnt_a", gnt_a, 0);
    chk("ar_data", out_data, 0);
    rst = 1'b0;

`ifdef MUX_ARB_STATS_EN
    do_reset();
    req_a = 1'b1; req_b = 1'b0; out_ready = 1'b1;
    repeat (70000) step();
    chk("st_cnt_a_sat", cnt_a, 16'hFFFF);
    chk("st_cnt_b_zero", cnt_b, 0);
    req_a = 1'b0; req_b = 1'b1;
    repeat (5) step();
    chk("st_cnt_b", cnt_b, 4);
    chk("st_cnt_a_hold", cnt_a, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
